// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory sequencing controller:
// access-type encodings, FSM states and beat-count decoding.
package dmem_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT  = 2'd1,
      ST_RWAIT = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic       legal;
      logic [2:0] beats;
   } beat_info_t;

   // Number of byte beats for an access type; illegal types report zero beats.
   function automatic beat_info_t beat_info(input logic [2:0] ctrl);
      beat_info_t bi;
      bi.legal = 1'b1;
      bi.beats = 3'd0;
      case (ctrl)
         CTRL_B, CTRL_BU: bi.beats = 3'd1;
         CTRL_H, CTRL_HU: bi.beats = 3'd2;
         CTRL_W:          bi.beats = 3'd4;
         default:         bi.legal = 1'b0;
      endcase
      return bi;
   endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin arbiter. On a tie the port not granted last wins;
// the last-grant register only moves when the owner accepts a grant.
module dmem_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       grant,
   output logic       last_grant
);

   // Grant index: a lone requester wins, a tie goes to the other port.
   always_comb begin
      grant = 1'b0;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last_grant;
         default: grant = 1'b0;
      endcase
   end

   // Remember the accepted grant; reset value makes port 0 win the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last_grant <= 1'b1;
      else if (update) last_grant <= grant;
   end

endmodule

// File: rtl/dmem_controller.sv
// Serializes byte/halfword/word accesses from two requesters onto a
// byte-wide synchronous-read RAM, little-endian, with load extension.
// Handshake: a port holds Req and its fields stable; the controller
// samples Req only in IDLE and answers with a one-cycle Done pulse.
module dmem_controller
   import dmem_pkg::*;
#(
   parameter int AW = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    Req,
   input  logic [1:0]    Wr,
   input  logic [2:0]    Ctrl0,
   input  logic [2:0]    Ctrl1,
   input  logic [31:0]   Addr0,
   input  logic [31:0]   Addr1,
   input  logic [31:0]   WData0,
   input  logic [31:0]   WData1,
   output logic [1:0]    Done,
   output logic [1:0]    Err,
   output logic [31:0]   RData,
   output logic [AW-1:0] MemAddr,
   output logic          MemWe,
   output logic [7:0]    MemWData,
   input  logic [7:0]    MemRData,
   output state_t        dbg_state
);

   state_t          state, state_nxt;
   logic            winner, wr_q, err_q;
   logic [2:0]      ctrl_q;
   logic [AW-1:0]   addr_q;
   logic [31:0]     wdata_q, asm_q, ext_data;
   logic [1:0]      cnt, last_q, cap_idx;
   logic            grant, last_grant, arb_update;
   logic            sel_wr;
   logic [2:0]      sel_ctrl;
   logic [31:0]     sel_addr, sel_wdata;
   beat_info_t      bi;
   logic            unused_bits;

   assign sel_wr     = grant ? Wr[1]  : Wr[0];
   assign sel_ctrl   = grant ? Ctrl1  : Ctrl0;
   assign sel_addr   = grant ? Addr1  : Addr0;
   assign sel_wdata  = grant ? WData1 : WData0;
   assign bi         = beat_info(sel_ctrl);
   assign arb_update = (state == ST_IDLE) && (Req != 2'b00);
   assign dbg_state  = state;
   // Read byte lands one cycle after issue: BEAT sees beat cnt-1, RWAIT the last.
   assign cap_idx    = (state == ST_RWAIT) ? last_q : cnt - 2'd1;
   assign unused_bits = ^{sel_addr[31:AW], bi.beats[2], last_grant};

   dmem_rr_arb u_arb (
      .clk        (clk),
      .rst        (rst),
      .req        (Req),
      .update     (arb_update),
      .grant      (grant),
      .last_grant (last_grant)
   );

   // FSM state register; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (Req != 2'b00) state_nxt = bi.legal ? ST_BEAT : ST_DONE;
         ST_BEAT:  if (cnt == last_q) state_nxt = wr_q ? ST_DONE : ST_RWAIT;
         ST_RWAIT: state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Latch the winning request, step the beat counter, assemble load bytes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         winner  <= 1'b0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         ctrl_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         last_q  <= '0;
         cnt     <= '0;
         asm_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_update) begin
                  winner  <= grant;
                  wr_q    <= sel_wr;
                  ctrl_q  <= sel_ctrl;
                  addr_q  <= sel_addr[AW-1:0];
                  wdata_q <= sel_wdata;
                  err_q   <= ~bi.legal;
                  last_q  <= bi.beats[1:0] - 2'd1;
                  cnt     <= '0;
                  asm_q   <= '0;
               end
            end
            ST_BEAT: begin
               cnt <= cnt + 2'd1;
               if (!wr_q && cnt != 2'd0) asm_q[{cap_idx, 3'b000} +: 8] <= MemRData;
            end
            ST_RWAIT: asm_q[{cap_idx, 3'b000} +: 8] <= MemRData;
            default: ;
         endcase
      end
   end

   // Sign or zero extension of the assembled load value.
   always_comb begin
      ext_data = 32'd0;
      case (ctrl_q)
         CTRL_B:  ext_data = {{24{asm_q[7]}}, asm_q[7:0]};
         CTRL_H:  ext_data = {{16{asm_q[15]}}, asm_q[15:0]};
         CTRL_W:  ext_data = asm_q;
         CTRL_BU: ext_data = {24'd0, asm_q[7:0]};
         CTRL_HU: ext_data = {16'd0, asm_q[15:0]};
         default: ext_data = 32'd0;
      endcase
   end

   // Outputs decode from state only, so reset silences MemWe at once.
   always_comb begin
      MemAddr  = '0;
      MemWe    = 1'b0;
      MemWData = 8'd0;
      Done     = 2'b00;
      Err      = 2'b00;
      RData    = 32'd0;
      case (state)
         ST_BEAT: begin
            MemAddr  = addr_q + {{(AW-2){1'b0}}, cnt};
            MemWe    = wr_q;
            MemWData = wdata_q[{cnt, 3'b000} +: 8];
         end
         ST_DONE: begin
            Done[winner] = 1'b1;
            Err[winner]  = err_q;
            if (!wr_q && !err_q) RData = ext_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: byte RAM model, directed vector table,
// arbitration and reset corner sequences, randomized traffic.
module tb_dmem_controller;
   import dmem_pkg::*;

   localparam int AW  = 11;
   localparam int MSZ = 2048;

   logic          clk, rst;
   logic [1:0]    Req, Wr;
   logic [2:0]    Ctrl0, Ctrl1;
   logic [31:0]   Addr0, Addr1, WData0, WData1;
   logic [1:0]    Done, Err;
   logic [31:0]   RData;
   logic [AW-1:0] MemAddr;
   logic          MemWe;
   logic [7:0]    MemWData, MemRData;
   state_t        dbg_state;

   logic          ram_init;
   logic [7:0]    ram     [0:MSZ-1];
   logic [7:0]    ref_mem [0:MSZ-1];
   int            checks, errors;

   typedef struct {
      int          port;
      logic        wr;
      logic [2:0]  ctrl;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          exp_lat;
   } vec_t;
   vec_t vecs[$];

   dmem_controller #(.AW(AW)) dut (
      .clk(clk), .rst(rst), .Req(Req), .Wr(Wr),
      .Ctrl0(Ctrl0), .Ctrl1(Ctrl1), .Addr0(Addr0), .Addr1(Addr1),
      .WData0(WData0), .WData1(WData1), .Done(Done), .Err(Err),
      .RData(RData), .MemAddr(MemAddr), .MemWe(MemWe),
      .MemWData(MemWData), .MemRData(MemRData), .dbg_state(dbg_state)
   );

   // Clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) % 256);
   endfunction

   // Byte-wide synchronous-read RAM.
   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < MSZ; i++) ram[i] <= init_byte(i);
      end else begin
         if (MemWe) ram[MemAddr] <= MemWData;
         MemRData <= ram[MemAddr];
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   function automatic int n_bytes(input logic [2:0] c);
      case (c)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   // Reference model: flat byte array, plain arithmetic for extension.
   task automatic model(input logic wr, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output int lat, output int we);
      int n, base;
      logic [31:0] v;
      n = n_bytes(ctrl);
      base = int'(addr % 32'd2048);
      rd = 32'd0; err = 1'b0; we = 0; v = 32'd0;
      if (n == 0) begin
         err = 1'b1; lat = 1;
      end else if (wr) begin
         for (int i = 0; i < n; i++) ref_mem[(base + i) % MSZ] = 8'((wdata >> (8 * i)) & 32'hFF);
         lat = n + 1; we = n;
      end else begin
         for (int i = 0; i < n; i++) v = v + (32'(ref_mem[(base + i) % MSZ]) << (8 * i));
         if (ctrl == 3'b000 && v >= 32'd128)   v = v + 32'hFFFF_FF00;
         if (ctrl == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
         rd = v; lat = n + 2;
      end
   endtask

   // Driver: raise one port's request in IDLE and wait (bounded) for its Done.
   task automatic do_access(input int port, input logic wr, input logic [2:0] ctrl,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic err, output int lat,
                            output int we);
      logic got;
      if (port == 0) begin
         Wr[0] = wr; Ctrl0 = ctrl; Addr0 = addr; WData0 = wdata;
      end else begin
         Wr[1] = wr; Ctrl1 = ctrl; Addr1 = addr; WData1 = wdata;
      end
      Req[port] = 1'b1;
      got = 1'b0; lat = 0; we = 0; rd = 32'd0; err = 1'b0;
      while (!got && lat < 40) begin
         @(negedge clk);
         lat++;
         if (MemWe) we++;
         if (Done[port]) begin
            got = 1'b1; rd = RData; err = Err[port];
         end
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL done_timeout port %0d got none exp Done", port);
      end
      Req[port] = 1'b0;
      @(negedge clk);
   endtask

   task automatic check_access(input string name, input int port, input logic wr,
                               input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rd,
                               input logic exp_err, input int exp_lat, input int exp_we);
      logic [31:0] rd;
      logic err;
      int lat, we;
      do_access(port, wr, ctrl, addr, wdata, rd, err, lat, we);
      chk({name, "_rdata"}, rd, exp_rd);
      chk({name, "_err"}, 32'(err), 32'(exp_err));
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_we_cycles"}, 32'(we), 32'(exp_we));
   endtask

   initial begin
      logic [31:0] m_rd, e0, e1, addr;
      logic m_err;
      int m_lat, m_we, cyc, exp_p;
      logic got, wr;
      logic [2:0] ctrl;
      int gaps[4];
      logic [7:0] old2, old3;

      checks = 0; errors = 0;
      gaps = '{6, 5, 7, 5};
      for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);

      // Reset block.
      rst = 1'b1; ram_init = 1'b1;
      Req = 2'b00; Wr = 2'b00; Ctrl0 = 3'd0; Ctrl1 = 3'd0;
      Addr0 = 32'd0; Addr1 = 32'd0; WData0 = 32'd0; WData1 = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_done", 32'(Done), 32'd0);
      chk("rst_err", 32'(Err), 32'd0);
      chk("rst_rdata", RData, 32'd0);
      chk("rst_memaddr", 32'(MemAddr), 32'd0);
      chk("rst_memwe", 32'(MemWe), 32'd0);
      chk("rst_memwdata", 32'(MemWData), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      rst = 1'b0; ram_init = 1'b0;
      @(negedge clk);

      // Directed table.
      vecs.push_back('{0, 1'b1, 3'b010, 32'h010, 32'h8899AABB, 32'h0, 1'b0, 5});
      vecs.push_back('{0, 1'b0, 3'b010, 32'h010, 32'h0, 32'h8899AABB, 1'b0, 6});
      vecs.push_back('{0, 1'b1, 3'b000, 32'h020, 32'h00000080, 32'h0, 1'b0, 2});
      vecs.push_back('{0, 1'b0, 3'b000, 32'h020, 32'h0, 32'hFFFFFF80, 1'b0, 3});
      vecs.push_back('{0, 1'b0, 3'b100, 32'h020, 32'h0, 32'h00000080, 1'b0, 3});
      vecs.push_back('{1, 1'b1, 3'b001, 32'h030, 32'h00009234, 32'h0, 1'b0, 3});
      vecs.push_back('{1, 1'b0, 3'b001, 32'h030, 32'h0, 32'hFFFF9234, 1'b0, 4});
      vecs.push_back('{0, 1'b0, 3'b101, 32'h030, 32'h0, 32'h00009234, 1'b0, 4});
      vecs.push_back('{1, 1'b1, 3'b010, 32'h7FE, 32'hCAFE1234, 32'h0, 1'b0, 5});
      vecs.push_back('{1, 1'b0, 3'b010, 32'h7FE, 32'h0, 32'hCAFE1234, 1'b0, 6});
      vecs.push_back('{0, 1'b0, 3'b010, 32'hFFFFF7FE, 32'h0, 32'hCAFE1234, 1'b0, 6});
      vecs.push_back('{0, 1'b1, 3'b011, 32'h050, 32'h12345678, 32'h0, 1'b1, 1});
      vecs.push_back('{1, 1'b0, 3'b110, 32'h010, 32'h0, 32'h0, 1'b1, 1});
      vecs.push_back('{0, 1'b1, 3'b111, 32'h060, 32'hFFFFFFFF, 32'h0, 1'b1, 1});
      vecs.push_back('{0, 1'b1, 3'b010, 32'h043, 32'h01020304, 32'h0, 1'b0, 5});
      vecs.push_back('{0, 1'b0, 3'b101, 32'h044, 32'h0, 32'h00000203, 1'b0, 4});
      vecs.push_back('{1, 1'b0, 3'b000, 32'h046, 32'h0, 32'h00000001, 1'b0, 3});
      for (int i = 0; i < vecs.size(); i++) begin
         model(vecs[i].wr, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, m_rd, m_err, m_lat, m_we);
         check_access($sformatf("vec%0d", i), vecs[i].port, vecs[i].wr, vecs[i].ctrl,
                      vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err,
                      vecs[i].exp_lat, m_we);
      end
      chk("ram_010", 32'(ram[11'h010]), 32'hBB);
      chk("ram_011", 32'(ram[11'h011]), 32'hAA);
      chk("ram_012", 32'(ram[11'h012]), 32'h99);
      chk("ram_013", 32'(ram[11'h013]), 32'h88);
      chk("ram_7fe", 32'(ram[11'h7FE]), 32'h34);
      chk("ram_7ff", 32'(ram[11'h7FF]), 32'h12);
      chk("ram_000", 32'(ram[11'h000]), 32'hFE);
      chk("ram_001", 32'(ram[11'h001]), 32'hCA);

      // Tie arbitration: port 1 granted last, then both hold Req continuously.
      model(1'b0, 3'b010, 32'h010, 32'h0, m_rd, m_err, m_lat, m_we);
      check_access("pre_tie", 1, 1'b0, 3'b010, 32'h010, 32'h0, m_rd, m_err, m_lat, m_we);
      model(1'b0, 3'b010, 32'h010, 32'h0, e0, m_err, m_lat, m_we);
      model(1'b0, 3'b101, 32'h030, 32'h0, e1, m_err, m_lat, m_we);
      Wr = 2'b00; Ctrl0 = 3'b010; Addr0 = 32'h010; Ctrl1 = 3'b101; Addr1 = 32'h030;
      Req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_p = k % 2;
         cyc = 0; got = 1'b0;
         while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (Done != 2'b00) got = 1'b1;
         end
         if (!got) begin
            checks++; errors++;
            $display("FAIL tie_timeout round %0d got none exp Done", k);
         end else begin
            chk($sformatf("tie%0d_done", k), 32'(Done), (exp_p == 1) ? 32'd2 : 32'd1);
            chk($sformatf("tie%0d_rdata", k), RData, (exp_p == 1) ? e1 : e0);
            chk($sformatf("tie%0d_gap", k), 32'(cyc), 32'(gaps[k]));
         end
      end
      Req = 2'b00;
      @(negedge clk);

      // Randomized traffic against the model.
      for (int i = 0; i < 150; i++) begin
         wr = 1'($urandom_range(0, 1));
         ctrl = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 2))
            0:       addr = $urandom;
            1:       addr = 32'($urandom_range(0, 95));
            default: addr = 32'($urandom_range(2040, 2047));
         endcase
         e0 = $urandom;
         model(wr, ctrl, addr, e0, m_rd, m_err, m_lat, m_we);
         check_access($sformatf("rnd%0d", i), int'($urandom_range(0, 1)), wr, ctrl, addr, e0,
                      m_rd, m_err, m_lat, m_we);
      end

      // Reset during beat 2 of a word store.
      old2 = ref_mem[12'h102]; old3 = ref_mem[12'h103];
      Wr[0] = 1'b1; Ctrl0 = 3'b010; Addr0 = 32'h100; WData0 = 32'h11223344;
      Req[0] = 1'b1;
      repeat (3) @(negedge clk);
      chk("rstmid_we_before", 32'(MemWe), 32'd1);
      chk("rstmid_addr_before", 32'(MemAddr), 32'h102);
      rst = 1'b1;
      #1;
      chk("rstmid_we_async", 32'(MemWe), 32'd0);
      chk("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
      Req = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("rstmid_nodone%0d", k), 32'(Done), 32'd0);
      end
      chk("rstmid_ram100", 32'(ram[11'h100]), 32'h44);
      chk("rstmid_ram101", 32'(ram[11'h101]), 32'h33);
      chk("rstmid_ram102", 32'(ram[11'h102]), 32'(old2));
      chk("rstmid_ram103", 32'(ram[11'h103]), 32'(old3));
      ref_mem[12'h100] = 8'h44; ref_mem[12'h101] = 8'h33;
      model(1'b0, 3'b010, 32'h100, 32'h0, m_rd, m_err, m_lat, m_we);
      check_access("post_rst", 1, 1'b0, 3'b010, 32'h100, 32'h0, m_rd, m_err, m_lat, m_we);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_controller.md
# dmem_controller

Sequencing controller that lets two requesters (port 0: CPU load/store unit, port 1: debug/DMA loader) share one byte-wide, single-port, synchronous-read data RAM. It arbitrates round-robin, serializes byte/halfword/word accesses into 1/2/4 byte beats (little-endian), and assembles read data with sign or zero extension per the data-memory control encoding. It sits between the core's memory stage and the RAM macro, replacing direct multi-byte combinational access.

## Interface
- AW, 11, RAM byte-address width (2048 bytes); address bits above AW-1 ignored
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- Req[1:0]  in  2  request per port, held with fields stable until Done
- Wr[1:0]  in  2  per port: 1 store, 0 load
- Ctrl0, Ctrl1  in  3 each  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- Addr0, Addr1  in  32 each  byte address of lowest byte
- WData0, WData1  in  32 each  store data, byte 0 = bits 7:0
- Done[1:0]  out  2  one-cycle completion pulse per port
- Err[1:0]  out  2  pulses with Done on illegal Ctrl
- RData  out  32  load result, valid in Done cycle of a load
- MemAddr  out  AW  RAM byte address
- MemWe  out  1  RAM write enable
- MemWData  out  8  RAM write byte
- MemRData  in  8  RAM read byte, registered: valid one cycle after MemAddr

## Operation
- States: IDLE, BEAT, RWAIT, DONE.
- IDLE: Req sampled only here. Winner chosen (see arbitration); its Wr/Ctrl/Addr/WData latched; beat count N = 1 (B/BU), 2 (H/HU), 4 (W); go BEAT, cnt=0.
- Illegal Ctrl (011, 110, 111): no RAM access; go DONE directly with Err pulse, RData=0.
- BEAT: MemAddr = (Addr + cnt) mod 2^AW; MemWe = Wr; MemWData = WData byte cnt. cnt increments each cycle. After beat N-1: store → DONE, load → RWAIT.
- Load assembly: byte returned for beat k (one cycle after issue) written into assembly byte k; RWAIT captures final byte.
- DONE: Done[winner]=1, Err as latched, RData = assembled value extended: B/H sign-extend from bit 7/15, BU/HU zero-extend, W unchanged. Stores: RData=0. Next state IDLE.
- Arbitration: single request wins; both requesting → port not granted last. Last-grant register resets to port 1 (port 0 wins first tie).
- No alignment requirement; multi-byte access crossing 2^AW wraps to address 0.
- A Req still high in the IDLE cycle after Done is a new request.

## Timing
- Reset values: Done=0, Err=0, RData=0, MemAddr=0, MemWe=0, MemWData=0, state IDLE, last-grant=1.
- Request sampled at edge ending IDLE cycle t; beats in cycles t+1..t+N.
- Store Done in cycle t+N+1; load Done in cycle t+N+2; illegal Done in cycle t+1.
- Throughput: one access per N+2 (store) or N+3 (load) cycles including IDLE.
- MemWe is high only in BEAT of a store; never in IDLE/RWAIT/DONE.
- Reset mid-access: immediate return to IDLE, MemWe low asynchronously, already-written bytes remain, no Done issued.
- Loser's Req held; serviced in next IDLE.

## Structure
- Package dmem_pkg: Ctrl encodings (CTRL_B, CTRL_H, CTRL_W, CTRL_BU, CTRL_HU), state enum, function returning beat count and legality from Ctrl.
- Sub-module dmem_rr_arb: 2-way round-robin arbiter (Req, update strobe, grant index, last-grant register).
- Byte RAM model for benches is not part of this block.

## Test plan
- Port 0 SW 0x8899AABB at 0x010 → bytes BB,AA,99,88 at 0x010..0x013, Done[0] at t+5; then LW 0x010 → RData=0x8899AABB, Done[0] at t+6.
- RAM[0x020]=0x80: LB → 0xFFFFFF80, LBU → 0x00000080; RAM[0x030..31]=0x34,0x92: LH → 0xFFFF9234, LHU → 0x00009234.
- Both ports request in same IDLE, repeated three times → grants 0,1,0; losing port keeps Req and receives Done after winner.
- Port 1 SW at 0x7FE (AW=11) → bytes at 0x7FE,0x7FF,0x000,0x001; LW 0x7FE returns same word.
- Ctrl=011 on port 0 → Done[0] and Err[0] at t+1, RData=0, MemWe never asserted.
- rst asserted during beat 2 of a word store → MemWe drops immediately, bytes 0–1 written, bytes 2–3 unchanged, no Done; next request serviced normally.
